// File: rtl/sm4_iter_core_if.sv
// Handshake bundle for the iterative SM4 engine: key load, block submit and result return.
interface sm4_iter_core_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         key_ok;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_dec;
  logic [127:0] blk;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res;
  logic         busy;

  modport master (
    output key_valid, key, blk_valid, blk_dec, blk, res_ready,
    input  key_ready, key_ok, blk_ready, res_valid, res, busy
  );

  modport slave (
    input  key_valid, key, blk_valid, blk_dec, blk, res_ready,
    output key_ready, key_ok, blk_ready, res_valid, res, busy
  );
endinterface

// File: rtl/sm4_iter_core.sv
// Iterative SM4 engine: one key-expansion or cipher round per clock through one shared
// S-box/T-transform. The 4-word window holds K during expansion and X during a block.
module sm4_iter_core #(
  parameter int unsigned NROUNDS  = 32,
  parameter bit          RES_HOLD = 1'b1
) (
  input logic            clk,
  input logic            rst,
  sm4_iter_core_if.slave bus
);
  typedef enum logic [2:0] {StIdle, StKexp, StReady, StCrypt, StDone} state_e;

  localparam logic [4:0]   LastRound = 5'(NROUNDS - 1);
  localparam logic [127:0] Fk        = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
  localparam logic [7:0]   Sbox [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  state_e       state_q, state_d;
  logic [4:0]   cnt_q;
  logic         fin_q, dec_q, key_ok_q, res_valid_q;
  logic [127:0] res_q;
  logic [31:0]  win_q [4];
  logic [31:0]  rk_q  [32];

  logic        key_ready, blk_ready, key_hs, blk_hs, last, cipher, round_en;
  logic [4:0]  rk_idx;
  logic [31:0] ck, rk_sel, t_in, t_out, new_word;

  // cip = 1 selects the cipher linear layer L, 0 the key-schedule layer L'.
  function automatic logic [31:0] t_fn(input logic [31:0] a, input logic cip);
    logic [31:0] b;
    logic [31:0] l;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = Sbox[a[8*j +: 8]];
    if (cip) begin
      l = b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^
          {b[7:0], b[31:8]};
    end else begin
      l = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    end
    return l;
  endfunction

  assign key_ready = (state_q == StIdle) | (state_q == StReady);
  assign blk_ready = (state_q == StReady) & ~bus.key_valid;
  assign key_hs    = bus.key_valid & key_ready;
  assign blk_hs    = bus.blk_valid & blk_ready;
  assign last      = (cnt_q == LastRound);
  assign cipher    = (state_q == StCrypt);
  // The extra CRYPT cycle with fin_q set only publishes the result.
  assign round_en  = (state_q == StKexp) | (cipher & ~fin_q);
  assign rk_idx    = dec_q ? (LastRound - cnt_q) : cnt_q;

  always_comb begin
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      ck[8*(3-j) +: 8] = 8'(({1'b0, cnt_q, 2'b00} + 8'(j)) * 8'd7);
    end
  end

  assign rk_sel   = cipher ? rk_q[rk_idx] : ck;
  assign t_in     = win_q[1] ^ win_q[2] ^ win_q[3] ^ rk_sel;
  assign t_out    = t_fn(t_in, cipher);
  assign new_word = win_q[0] ^ t_out;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (key_hs) state_d = StKexp;
      StKexp:  if (last) state_d = StReady;
      StReady: begin
        if (key_hs)      state_d = StKexp;
        else if (blk_hs) state_d = StCrypt;
      end
      StCrypt: if (fin_q) state_d = StDone;
      StDone:  if (bus.res_ready) state_d = StReady;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
      dec_q       <= 1'b0;
      key_ok_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle, StReady: begin
          if (key_hs) begin
            cnt_q    <= '0;
            key_ok_q <= 1'b0;
          end else if (blk_hs) begin
            cnt_q <= '0;
            fin_q <= 1'b0;
            dec_q <= bus.blk_dec;
          end
        end
        StKexp: begin
          if (last) key_ok_q <= 1'b1;
          else      cnt_q    <= cnt_q + 5'd1;
        end
        StCrypt: begin
          if (fin_q) begin
            res_valid_q <= 1'b1;
            res_q       <= {win_q[3], win_q[2], win_q[1], win_q[0]};
          end else if (last) begin
            fin_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StDone: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (!RES_HOLD) res_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Window and round-key file carry no reset; key_ok_q guards their validity.
  always_ff @(posedge clk) begin
    if (key_hs) begin
      for (int w = 0; w < 4; w++) win_q[w] <= bus.key[127-32*w -: 32] ^ Fk[127-32*w -: 32];
    end else if (blk_hs) begin
      for (int w = 0; w < 4; w++) win_q[w] <= bus.blk[127-32*w -: 32];
    end else if (round_en) begin
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= win_q[3];
      win_q[3] <= new_word;
    end
    if (state_q == StKexp) rk_q[cnt_q] <= new_word;
  end

  assign bus.key_ready = key_ready;
  assign bus.blk_ready = blk_ready;
  assign bus.key_ok    = key_ok_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res       = res_q;
  assign bus.busy      = (state_q == StKexp) | (state_q == StCrypt);
endmodule

// File: tb/tb_sm4_iter_core.sv
// Randomised bench for sm4_iter_core against a word-level software SM4 model and a
// latency-based handshake model, checked on every falling edge.
module tb_sm4_iter_core;
  localparam logic [127:0] MK = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [31:0] FK_W [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };
  localparam int M_IDLE = 0, M_KEXP = 1, M_READY = 2, M_CRYPT = 3, M_DONE = 4;

  typedef logic [31:0] rk_t [32];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  sm4_iter_core_if ifc ();
  sm4_iter_core #(.NROUNDS(32), .RES_HOLD(1'b1)) dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] sw_t(input logic [31:0] a, input bit cip);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = SBOX[a[8*j +: 8]];
    if (cip) return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  function automatic rk_t sw_expand(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] ck;
    rk_t rk;
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ FK_W[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
      k[i+4] = k[i] ^ sw_t(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck, 1'b0);
      rk[i] = k[i+4];
    end
    return rk;
  endfunction

  function automatic logic [127:0] sw_crypt(input logic [127:0] b, input bit dec, input rk_t rk);
    logic [31:0] x [36];
    for (int i = 0; i < 4; i++) x[i] = b[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      x[i+4] = x[i] ^ sw_t(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk[dec ? 31 - i : i], 1'b1);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural handshake model: phases advance by the documented latencies.
  int           m_st = M_IDLE;
  int           m_left = 0;
  logic         m_keyok = 1'b0, m_rv = 1'b0;
  logic [127:0] m_res = '0, m_pend = '0;
  rk_t          m_rk;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_st = M_IDLE; m_keyok = 1'b0; m_rv = 1'b0; m_res = '0;
      end else begin
        case (m_st)
          M_IDLE, M_READY: begin
            if (ifc.key_valid) begin
              m_st = M_KEXP; m_left = 32; m_keyok = 1'b0; m_rk = sw_expand(ifc.key);
            end else if (m_st == M_READY && ifc.blk_valid) begin
              m_st = M_CRYPT; m_left = 33; m_pend = sw_crypt(ifc.blk, ifc.blk_dec, m_rk);
            end
          end
          M_KEXP: begin
            m_left--;
            if (m_left == 0) begin m_st = M_READY; m_keyok = 1'b1; end
          end
          M_CRYPT: begin
            m_left--;
            if (m_left == 0) begin m_st = M_DONE; m_rv = 1'b1; m_res = m_pend; end
          end
          default: if (ifc.res_ready) begin m_rv = 1'b0; m_st = M_READY; end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("key_ready", ifc.key_ready, (m_st == M_IDLE) || (m_st == M_READY));
      check("blk_ready", ifc.blk_ready, (m_st == M_READY) && !ifc.key_valid);
      check("busy", ifc.busy, (m_st == M_KEXP) || (m_st == M_CRYPT));
      check("key_ok", ifc.key_ok, m_keyok);
      check("res_valid", ifc.res_valid, m_rv);
      check("res", ifc.res, m_res);
    end
  end

  task automatic send_key(input logic [127:0] k);
    int n = 0;
    ifc.key = k; ifc.key_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!ifc.key_ready && n < 200);
    check("key_accept_timeout", ifc.key_ready, 1'b1);
    @(posedge clk); #1 ifc.key_valid = 1'b0;
  endtask

  task automatic send_blk(input logic [127:0] b, input bit dec);
    int n = 0;
    ifc.blk = b; ifc.blk_dec = dec; ifc.blk_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!ifc.blk_ready && n < 200);
    check("blk_accept_timeout", ifc.blk_ready, 1'b1);
    @(posedge clk); #1 ifc.blk_valid = 1'b0;
  endtask

  // which: 0 = key_ok, 1 = res_valid; exp_lat < 0 skips the latency comparison.
  task automatic wait_flag(input string name, input int which, input int exp_lat);
    int n = 0;
    logic f = 1'b0;
    while (!f && n < 100) begin
      @(posedge clk); #1 n++;
      f = (which == 0) ? ifc.key_ok : ifc.res_valid;
    end
    check({name, "_seen"}, f, 1'b1);
    if (exp_lat >= 0) check({name, "_latency"}, n, exp_lat);
  endtask

  task automatic consume();
    @(posedge clk); #1 ifc.res_ready = 1'b1;
    @(posedge clk); #1 ifc.res_ready = 1'b0;
  endtask

  initial begin
    rk_t r;
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    rk_t r;
    ifc.key_valid = 1'b0; ifc.key = '0; ifc.blk_valid = 1'b0; ifc.blk_dec = 1'b0;
    ifc.blk = '0; ifc.res_ready = 1'b0;

    // Pin the software model to the published vectors.
    r = sw_expand(MK);
    check("model_rk0", r[0], 32'hf12186f9);
    check("model_rk31", r[31], 32'h9124a012);
    check("model_enc", sw_crypt(PT, 1'b0, r), CT);
    check("model_dec", sw_crypt(CT, 1'b1, r), PT);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_key_ok", ifc.key_ok, 1'b0);
    check("reset_res", ifc.res, 128'd0);

    send_key(MK);
    wait_flag("kexp", 0, 32);
    send_blk(PT, 1'b0);
    wait_flag("enc", 1, 33);
    check("enc_res", ifc.res, CT);

    repeat (10) begin
      @(negedge clk);
      check("hold_res", ifc.res, CT);
      check("hold_blk_ready", ifc.blk_ready, 1'b0);
    end
    consume();
    ifc.blk = CT; ifc.blk_dec = 1'b1; ifc.blk_valid = 1'b1;
    @(negedge clk);
    check("ready_after_done", ifc.blk_ready, 1'b1);
    @(posedge clk); #1 ifc.blk_valid = 1'b0;
    check("busy_after_accept", ifc.busy, 1'b1);
    wait_flag("dec", 1, 33);
    check("dec_res", ifc.res, PT);
    consume();

    // Key and block together: key wins, block waits for the new key file.
    ifc.blk = PT; ifc.blk_dec = 1'b0; ifc.blk_valid = 1'b1;
    ifc.key = MK; ifc.key_valid = 1'b1;
    @(negedge clk);
    check("prio_blk_ready", ifc.blk_ready, 1'b0);
    @(posedge clk); #1 ifc.key_valid = 1'b0;
    check("prio_key_ok_drop", ifc.key_ok, 1'b0);
    send_blk(PT, 1'b0);
    check("prio_key_ok", ifc.key_ok, 1'b1);
    wait_flag("prio_enc", 1, 33);
    check("prio_res", ifc.res, CT);
    consume();

    for (int k = 0; k < 3; k++) begin
      send_key({$urandom, $urandom, $urandom, $urandom});
      wait_flag("rnd_kexp", 0, 32);
      for (int b = 0; b < 3; b++) begin
        ifc.res_ready = ($urandom_range(0, 2) == 0);
        send_blk({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        if (ifc.res_ready) begin
          repeat (36) @(posedge clk);
          #1 ifc.res_ready = 1'b0;
        end else begin
          wait_flag("rnd_crypt", 1, 33);
          repeat ($urandom_range(0, 4)) @(posedge clk);
          consume();
        end
      end
    end

    // Abort in the middle of a block.
    send_key(MK);
    wait_flag("pre_abort", 0, -1);
    send_blk(PT, 1'b0);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", ifc.busy, 1'b0);
    check("abort_key_ok", ifc.key_ok, 1'b0);
    check("abort_res_valid", ifc.res_valid, 1'b0);
    check("abort_res", ifc.res, 128'd0);
    check("abort_blk_ready", ifc.blk_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    ifc.blk = PT; ifc.blk_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("abort_no_blk", ifc.blk_ready, 1'b0);
    end
    ifc.blk_valid = 1'b0;
    send_key(MK);
    wait_flag("re_kexp", 0, 32);
    send_blk(CT, 1'b1);
    wait_flag("re_dec", 1, 33);
    check("re_dec_res", ifc.res, PT);
    consume();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
